dot_display: RTL and testbench

DOT_DISPLAY -- requirements
Module: dot_display

---
 rtl/dot_display.sv | 199 +++++++++++++++++++
 tb/tb_dot_display.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dot_display.sv
`default_nettype none
// ============================================================================
//  Module   : dot_display
//  Purpose  : Serial driver for a two-character dot-matrix LED display.
//             After reset it holds the display in reset, loads control
//             word 0, then streams 80-bit dot frames continuously.
//  Revision : 1.0  initial release
// ============================================================================
module dot_display #(
    parameter int         DIV         = 4,
    parameter int         RESET_TICKS = 16,
    parameter logic [7:0] CTRL_WORD   = 8'h7F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] dots,
    output logic        disp_blank,
    output logic        disp_clock,
    output logic        disp_data_out,
    output logic        disp_rs,
    output logic        disp_ce_b,
    output logic        disp_reset_b,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_CTRL  = 3'd1,
        S_CGAP  = 3'd2,
        S_DOTS  = 3'd3,
        S_DGAP  = 3'd4
    } state_t;

    localparam int              DW           = $clog2(DIV);
    localparam logic [DW-1:0]   c_div_last   = DW'(DIV - 1);
    localparam logic [15:0]     c_reset_last = 16'(RESET_TICKS - 1);
    // Control gap is two ticks; the dot gap holds ce_b high for four ticks
    // so that one frame (160 shift ticks + gap) spans 164 ticks.
    localparam logic [15:0]     c_cgap_last  = 16'd1;
    localparam logic [15:0]     c_dgap_last  = 16'd3;
    localparam logic [6:0]      c_ctrl_last  = 7'd7;
    localparam logic [6:0]      c_dots_last  = 7'd79;

    logic [DW-1:0] r_div_cnt;
    logic          w_tick;

    state_t        r_state,  w_state_n;
    logic [15:0]   r_wait,   w_wait_n;
    logic [6:0]    r_bit,    w_bit_n;
    logic          r_phase,  w_phase_n;
    logic [79:0]   r_shreg,  w_shreg_n;
    logic [6:0]    w_bit_last;

    logic          w_blank_n;
    logic          w_clock_n;
    logic          w_data_n;
    logic          w_rs_n;
    logic          w_ce_b_n;
    logic          w_reset_b_n;
    logic          w_frame_done_n;

    // Free-running tick divider: one-clk strobe every DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
        end
    end

    assign w_tick     = (r_div_cnt == c_div_last);
    assign w_bit_last = (r_state == S_CTRL) ? c_ctrl_last : c_dots_last;

    // State, counters, shift register and display pins; all pin changes
    // are only computed on tick cycles, so they move on tick edges only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RESET;
            r_wait        <= '0;
            r_bit         <= '0;
            r_phase       <= 1'b0;
            r_shreg       <= '0;
            disp_blank    <= 1'b1;
            disp_clock    <= 1'b0;
            disp_data_out <= 1'b0;
            disp_rs       <= 1'b0;
            disp_ce_b     <= 1'b1;
            disp_reset_b  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_wait        <= w_wait_n;
            r_bit         <= w_bit_n;
            r_phase       <= w_phase_n;
            r_shreg       <= w_shreg_n;
            disp_blank    <= w_blank_n;
            disp_clock    <= w_clock_n;
            disp_data_out <= w_data_n;
            disp_rs       <= w_rs_n;
            disp_ce_b     <= w_ce_b_n;
            disp_reset_b  <= w_reset_b_n;
            frame_done    <= w_frame_done_n;
        end
    end

    // Next-state and next-pin logic; everything holds unless a tick occurs.
    always_comb begin
        w_state_n      = r_state;
        w_wait_n       = r_wait;
        w_bit_n        = r_bit;
        w_phase_n      = r_phase;
        w_shreg_n      = r_shreg;
        w_blank_n      = disp_blank;
        w_clock_n      = disp_clock;
        w_data_n       = disp_data_out;
        w_rs_n         = disp_rs;
        w_ce_b_n       = disp_ce_b;
        w_reset_b_n    = disp_reset_b;
        w_frame_done_n = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_RESET: begin
                    if (r_wait == c_reset_last) begin
                        // Release display reset and present control bit 7.
                        w_state_n   = S_CTRL;
                        w_wait_n    = '0;
                        w_bit_n     = '0;
                        w_phase_n   = 1'b0;
                        w_shreg_n   = {CTRL_WORD, 72'h0};
                        w_reset_b_n = 1'b1;
                        w_rs_n      = 1'b1;
                        w_ce_b_n    = 1'b0;
                        w_clock_n   = 1'b0;
                        w_data_n    = CTRL_WORD[7];
                    end else begin
                        w_wait_n = r_wait + 16'd1;
                    end
                end

                S_CTRL, S_DOTS: begin
                    if (!r_phase) begin
                        // Phase B: rising serial clock, data held.
                        w_phase_n = 1'b1;
                        w_clock_n = 1'b1;
                    end else if (r_bit == w_bit_last) begin
                        // Last bit done: raise ce_b to latch the word.
                        w_phase_n = 1'b0;
                        w_bit_n   = '0;
                        w_wait_n  = '0;
                        w_clock_n = 1'b0;
                        w_data_n  = 1'b0;
                        w_ce_b_n  = 1'b1;
                        if (r_state == S_CTRL) begin
                            w_state_n = S_CGAP;
                            w_blank_n = 1'b0;
                        end else begin
                            w_state_n      = S_DGAP;
                            w_frame_done_n = 1'b1;
                        end
                    end else begin
                        // Phase A of the next bit: clock low, new data.
                        w_phase_n = 1'b0;
                        w_bit_n   = r_bit + 7'd1;
                        w_clock_n = 1'b0;
                        w_shreg_n = {r_shreg[78:0], 1'b0};
                        w_data_n  = r_shreg[78];
                    end
                end

                S_CGAP, S_DGAP: begin
                    if (r_wait == ((r_state == S_CGAP) ? c_cgap_last : c_dgap_last)) begin
                        // Snapshot the bitmap and present dot bit 79.
                        w_state_n = S_DOTS;
                        w_wait_n  = '0;
                        w_bit_n   = '0;
                        w_phase_n = 1'b0;
                        w_shreg_n = dots;
                        w_rs_n    = 1'b0;
                        w_ce_b_n  = 1'b0;
                        w_clock_n = 1'b0;
                        w_data_n  = dots[79];
                    end else begin
                        w_wait_n = r_wait + 16'd1;
                    end
                end

                default: begin
                    w_state_n = S_RESET;
                    w_wait_n  = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot_display
//  Purpose  : Randomized scoreboard bench for dot_display (DIV=4 main
//             instance, DIV=2 instance for timing scaling).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dot_display;

    localparam int         DIV     = 4;
    localparam int         RT      = 16;
    localparam logic [7:0] CW      = 8'h7F;
    // Frame capture happens after reset ticks, 16 control ticks, 2 gap ticks.
    localparam int         FIRST   = (RT + 18) * DIV;
    localparam int         PERIOD  = 164 * DIV;
    localparam logic [39:0] GLYPH1 = 40'h00_42_7F_40_00;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [79:0] dots = '0;

    logic disp_blank, disp_clock, disp_data_out, disp_rs, disp_ce_b, disp_reset_b, frame_done;
    logic b2, c2, d2, rs2, ce2, rb2, fd2;

    int total = 0;
    int bad   = 0;

    dot_display #(.DIV(DIV), .RESET_TICKS(RT), .CTRL_WORD(CW)) u_dut (
        .clk(clk), .reset(reset), .dots(dots),
        .disp_blank(disp_blank), .disp_clock(disp_clock), .disp_data_out(disp_data_out),
        .disp_rs(disp_rs), .disp_ce_b(disp_ce_b), .disp_reset_b(disp_reset_b),
        .frame_done(frame_done)
    );

    dot_display #(.DIV(2), .RESET_TICKS(4), .CTRL_WORD(CW)) u_dut2 (
        .clk(clk), .reset(reset), .dots(dots),
        .disp_blank(b2), .disp_clock(c2), .disp_data_out(d2),
        .disp_rs(rs2), .disp_ce_b(ce2), .disp_reset_b(rb2),
        .frame_done(fd2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: the bitmap present at each capture instant is the
    // frame the display must receive next.
    logic [79:0] exp_q[$];
    int e1 = 0;
    always @(posedge clk) begin
        if (reset) begin
            e1 = 0;
        end else begin
            e1 = e1 + 1;
            if (e1 >= FIRST && ((e1 - FIRST) % PERIOD) == 0)
                exp_q.push_back(dots);
        end
    end

    // Monitor for the main instance: rebuild words from serial clock rises.
    logic [79:0] acc = '0;
    int  nbits = 0, ce_bad = 0, cyc = 0, last_fd = -1;
    int  ctrl_frames = 0, dot_frames = 0;
    logic acc_rs = 1'b0, ctrl_seen = 1'b0;
    logic pclk = 1'b0, pce = 1'b1, pfd = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            acc = '0; nbits = 0; ce_bad = 0; last_fd = -1;
            ctrl_seen = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (disp_clock && !pclk) begin
                acc = {acc[78:0], disp_data_out};
                nbits++;
                acc_rs = disp_rs;
                if (disp_ce_b) ce_bad++;
            end
            if (disp_ce_b && !pce) begin
                if (acc_rs) begin
                    chk("ctrl_bits", 80'(nbits), 80'd8);
                    chk("ctrl_word", {72'h0, acc[7:0]}, {72'h0, CW});
                    ctrl_seen = 1'b1;
                    ctrl_frames++;
                end else begin
                    if (exp_q.size() == 0) begin
                        chk("frame_expected", 80'd0, 80'd1);
                    end else begin
                        chk("frame_data", acc, exp_q.pop_front());
                    end
                    chk("frame_bits", 80'(nbits), 80'd80);
                    chk("frame_done_at_latch", {79'h0, frame_done}, 80'd1);
                    dot_frames++;
                end
                chk("clock_rise_ce_low", 80'(ce_bad), 80'd0);
                acc = '0; nbits = 0; ce_bad = 0;
            end
            if (frame_done) begin
                chk("fd_width", {79'h0, pfd}, 80'd0);
                chk("fd_after_ctrl", {79'h0, ctrl_seen}, 80'd1);
                if (last_fd >= 0) chk("fd_period", 80'(cyc - last_fd), 80'(PERIOD));
                last_fd = cyc;
            end
        end
        pclk = disp_clock;
        pce  = disp_ce_b;
        pfd  = frame_done;
    end

    // Monitor for the DIV=2 instance: frame period scaling.
    int cyc2 = 0, last2 = -1, n2 = 0;
    logic pfd2 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            last2 = -1;
        end else begin
            cyc2++;
            if (fd2) begin
                chk("fd2_width", {79'h0, pfd2}, 80'd0);
                if (last2 >= 0) begin
                    chk("fd2_period", 80'(cyc2 - last2), 80'd328);
                    n2++;
                end
                last2 = cyc2;
            end
        end
        pfd2 = fd2;
    end

    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (e1 < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) chk("wait_timeout", 80'd1, 80'd0);
    endtask

    initial begin
        int n, k, c;
        reset = 1'b1;
        dots  = '0;
        repeat (3) @(negedge clk);
        chk("rst_reset_b", {79'h0, disp_reset_b}, 80'd0);
        chk("rst_blank",   {79'h0, disp_blank},   80'd1);
        chk("rst_ce_b",    {79'h0, disp_ce_b},    80'd1);
        chk("rst_rs",      {79'h0, disp_rs},      80'd0);
        chk("rst_clock",   {79'h0, disp_clock},   80'd0);
        chk("rst_data",    {79'h0, disp_data_out},80'd0);
        chk("rst_fd",      {79'h0, frame_done},   80'd0);
        reset = 1'b0;

        n = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (disp_reset_b) break;
        end
        chk("reset_b_low_clks", 80'(n), 80'(RT * DIV));

        // Frame 0 carries all zeros; frame 1 carries the '1' glyph.
        wait_edge(FIRST);
        dots = {40'h0, GLYPH1};
        // Change during frame 1's shift: frame 1 keeps the glyph.
        wait_edge(FIRST + PERIOD + 80 * DIV);
        dots = {16'($urandom), $urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            wait_edge(e1 + int'($urandom_range(1, PERIOD)));
            dots = {16'($urandom), $urandom, $urandom};
        end

        // Abort a frame during dot bit 40.
        k = (e1 - FIRST) / PERIOD + 1;
        c = FIRST + k * PERIOD;
        wait_edge(c + 80 * DIV + 1);
        reset = 1'b1;
        #1;
        chk("abort_ce_b",    {79'h0, disp_ce_b},    80'd1);
        chk("abort_reset_b", {79'h0, disp_reset_b}, 80'd0);
        chk("abort_clock",   {79'h0, disp_clock},   80'd0);
        chk("abort_fd",      {79'h0, frame_done},   80'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dots = {16'($urandom), $urandom, $urandom};
        wait_edge(FIRST + PERIOD / 2);
        dots = {16'($urandom), $urandom, $urandom};
        wait_edge(FIRST + 3 * PERIOD + 10);

        chk("ctrl_frames", 80'(ctrl_frames), 80'd2);
        chk("dot_frames_min", {79'h0, dot_frames >= 6}, 80'd1);
        chk("div2_periods_min", {79'h0, n2 >= 4}, 80'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
